// File: rtl/viterbi_pkg.sv
// Shared types and helper functions for the hard-decision Viterbi decoder core.
package viterbi_pkg;

    typedef logic [7:0] sreg_t;   // encoder register window, wide enough for K up to 8
    typedef logic [1:0] sym_t;
    typedef logic [1:0] bm_t;     // branch metric, Hamming distance 0..2

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_ACS  = 2'd1,
        FSM_TB   = 2'd2,
        FSM_OUT  = 2'd3
    } fsm_e;

    function automatic logic parity8(input sreg_t v);
        return ^v;
    endfunction

    function automatic sym_t expected_sym(input sreg_t sr, input sreg_t g0, input sreg_t g1);
        return {parity8(sr & g0), parity8(sr & g1)};
    endfunction

    function automatic bm_t hamming2(input sym_t a, input sym_t b);
        sym_t x;
        x = a ^ b;
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Single-state add-compare-select: two saturating candidates, smaller wins, tie picks d=0.
module viterbi_acs_unit
    import viterbi_pkg::*;
#(
    parameter int Wm = 6
) (
    input  logic [Wm-1:0] pm0,
    input  bm_t           bm0,
    input  logic [Wm-1:0] pm1,
    input  bm_t           bm1,
    output logic [Wm-1:0] metric,
    output logic          dec
);

    localparam logic [Wm:0] SAT = {1'b0, {Wm{1'b1}}};

    logic [Wm:0]   sum0;
    logic [Wm:0]   sum1;
    logic [Wm-1:0] c0;
    logic [Wm-1:0] c1;

    // One extra bit of headroom so overflow can be clamped to the all-ones metric.
    always_comb begin
        sum0   = {1'b0, pm0} + {{(Wm-1){1'b0}}, bm0};
        sum1   = {1'b0, pm1} + {{(Wm-1){1'b0}}, bm1};
        c0     = (sum0 > SAT) ? {Wm{1'b1}} : sum0[Wm-1:0];
        c1     = (sum1 > SAT) ? {Wm{1'b1}} : sum1[Wm-1:0];
        dec    = (c1 < c0);
        metric = dec ? c1 : c0;
    end

endmodule

// File: rtl/tt_um_viterbi_core.sv
// Serial hard-decision Viterbi decoder: one ACS per cycle, circular survivor memory, D-deep traceback.
// Define VITERBI_BEST_STATE_EN to start traceback at the best-metric state unless force_state0 is high.
module tt_um_viterbi_core
    import viterbi_pkg::*;
#(
    parameter int          K      = 3,
    parameter int          D      = 6,
    parameter int          Wm     = 6,
    parameter logic [7:0]  G0_OCT = 8'o07,
    parameter logic [7:0]  G1_OCT = 8'o05
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_sym_valid,
    output logic       rx_sym_ready,
    input  logic [1:0] rx_sym,
    output logic       dec_bit_valid,
    output logic       dec_bit,
    input  logic       force_state0
);

    localparam int M  = K - 1;
    localparam int NS = 1 << M;
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);

    localparam logic [PW-1:0] PTR_LAST    = PW'(D - 1);
    localparam logic [CW-1:0] CNT_FULL    = CW'(D);
    localparam logic [M-1:0]  IDX_LAST    = M'(NS - 1);
    localparam logic [Wm-1:0] METRIC_INIT = Wm'(1) << (Wm - 2);

    fsm_e          state_q, state_d;
    logic [M-1:0]  acs_idx_q, acs_idx_d;
    sym_t          sym_q, sym_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] tb_cnt_q, tb_cnt_d;
    logic [PW-1:0] tb_row_q, tb_row_d;
    logic [M-1:0]  tb_state_q, tb_state_d;
    logic          rdy_q, rdy_d;
    logic          vld_q, vld_d;
    logic          bit_q, bit_d;
    logic [Wm-1:0] metric_q [NS];
    logic [Wm-1:0] metric_d [NS];
    logic [Wm-1:0] nm_q [NS];
    logic [Wm-1:0] nm_d [NS];
    logic [NS-1:0] surv_q [D];
    logic [NS-1:0] surv_d [D];

    logic [M-1:0]  p0;
    logic [M-1:0]  p1;
    sreg_t         sr0;
    sreg_t         sr1;
    bm_t           bm0;
    bm_t           bm1;
    logic [Wm-1:0] acs_metric;
    logic          acs_dec;
    logic [Wm-1:0] min_m;
    logic [M-1:0]  tb_start;

    // Predecessors of state s are {d, s[M-1:1]}; the branch register is {d, s}.
    always_comb begin
        p0       = acs_idx_q >> 1;
        p1       = p0;
        p1[M-1]  = 1'b1;
        sr0      = sreg_t'(acs_idx_q);
        sr1      = sr0;
        sr1[M]   = 1'b1;
        bm0      = hamming2(sym_q, expected_sym(sr0, G0_OCT, G1_OCT));
        bm1      = hamming2(sym_q, expected_sym(sr1, G0_OCT, G1_OCT));
    end

    viterbi_acs_unit #(.Wm(Wm)) u_acs (
        .pm0    (metric_q[p0]),
        .bm0    (bm0),
        .pm1    (metric_q[p1]),
        .bm1    (bm1),
        .metric (acs_metric),
        .dec    (acs_dec)
    );

`ifdef VITERBI_BEST_STATE_EN
    logic [M-1:0] best_state;

    // Lowest index wins a tie because only a strictly smaller metric replaces the candidate.
    always_comb begin
        best_state = '0;
        for (int i = 1; i < NS; i++) begin
            best_state = (metric_q[i] < metric_q[best_state]) ? M'(i) : best_state;
        end
    end

    assign tb_start = force_state0 ? '0 : best_state;
`else
    logic unused_force;

    assign unused_force = force_state0;
    assign tb_start     = '0;
`endif

    // Sequencing: accept, ACS sweep over all states, traceback, single-cycle output.
    always_comb begin
        state_d    = state_q;
        acs_idx_d  = acs_idx_q;
        sym_d      = sym_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        tb_cnt_d   = tb_cnt_q;
        tb_row_d   = tb_row_q;
        tb_state_d = tb_state_q;
        bit_d      = bit_q;
        vld_d      = 1'b0;
        metric_d   = metric_q;
        nm_d       = nm_q;
        surv_d     = surv_q;
        min_m      = '0;
        case (state_q)
            FSM_IDLE: begin
                if (rx_sym_valid && rdy_q) begin
                    state_d   = FSM_ACS;
                    sym_d     = rx_sym;
                    acs_idx_d = '0;
                    cnt_d     = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
                end else begin
                    state_d = FSM_IDLE;
                end
            end
            FSM_ACS: begin
                nm_d[acs_idx_q]             = acs_metric;
                surv_d[ptr_q][acs_idx_q]    = acs_dec;
                acs_idx_d                   = acs_idx_q + 1'b1;
                if (acs_idx_q == IDX_LAST) begin
                    min_m = nm_d[0];
                    for (int i = 1; i < NS; i++) begin
                        min_m = (nm_d[i] < min_m) ? nm_d[i] : min_m;
                    end
                    for (int i = 0; i < NS; i++) begin
                        metric_d[i] = nm_d[i] - min_m;
                    end
                    ptr_d    = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
                    tb_cnt_d = '0;
                    state_d  = (cnt_q >= CNT_FULL) ? FSM_TB : FSM_IDLE;
                end else begin
                    state_d = FSM_ACS;
                end
            end
            FSM_TB: begin
                // ptr_q has already advanced, so the newest row sits one behind it.
                if (tb_cnt_q == '0) begin
                    tb_state_d = tb_start;
                    tb_row_d   = (ptr_q == '0) ? PTR_LAST : ptr_q - 1'b1;
                end else begin
                    tb_state_d      = tb_state_q >> 1;
                    tb_state_d[M-1] = surv_q[tb_row_q][tb_state_q];
                    tb_row_d        = (tb_row_q == '0) ? PTR_LAST : tb_row_q - 1'b1;
                end
                tb_cnt_d = tb_cnt_q + 1'b1;
                state_d  = (tb_cnt_q == PTR_LAST) ? FSM_OUT : FSM_TB;
            end
            FSM_OUT: begin
                state_d = FSM_IDLE;
                vld_d   = 1'b1;
                bit_d   = tb_state_q[0];
            end
            default: begin
                state_d = FSM_IDLE;
            end
        endcase
        rdy_d = (state_d == FSM_IDLE);
    end

    // State registers; reset clears everything and restores the initial metric spread.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FSM_IDLE;
            acs_idx_q  <= '0;
            sym_q      <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            tb_cnt_q   <= '0;
            tb_row_q   <= '0;
            tb_state_q <= '0;
            rdy_q      <= 1'b0;
            vld_q      <= 1'b0;
            bit_q      <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                metric_q[i] <= (i == 0) ? '0 : METRIC_INIT;
                nm_q[i]     <= '0;
            end
            for (int r = 0; r < D; r++) begin
                surv_q[r] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acs_idx_q  <= acs_idx_d;
            sym_q      <= sym_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            tb_cnt_q   <= tb_cnt_d;
            tb_row_q   <= tb_row_d;
            tb_state_q <= tb_state_d;
            rdy_q      <= rdy_d;
            vld_q      <= vld_d;
            bit_q      <= bit_d;
            metric_q   <= metric_d;
            nm_q       <= nm_d;
            surv_q     <= surv_d;
        end
    end

    assign rx_sym_ready  = rdy_q;
    assign dec_bit_valid = vld_q;
    assign dec_bit       = bit_q;

endmodule

// File: tb/tb_tt_um_viterbi_core.sv
// Bench for tt_um_viterbi_core: directed vectors plus random streams scored against
// a register-exchange Viterbi model (full survivor paths, no traceback memory).
module tb_tt_um_viterbi_core;

    localparam int M   = 2;
    localparam int NS  = 4;
    localparam int D   = 6;
    localparam int WM  = 6;
    localparam int LAT = NS + D + 1;
    localparam int SAT = (1 << WM) - 1;
    localparam int G0  = 7;
    localparam int G1  = 5;
`ifdef VITERBI_BEST_STATE_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx_sym_valid;
    logic       rx_sym_ready;
    logic [1:0] rx_sym;
    logic       dec_bit_valid;
    logic       dec_bit;
    logic       force_state0;

    int n_checks;
    int n_errors;
    int cyc;
    int strobes;
    int last_bit;
    int ones;
    int enc_st;

    int              pm [NS];
    longint unsigned path [NS];
    int              m_cnt;
    int              exp_bit_q [$];
    int              exp_cyc_q [$];

    logic [1:0] v037 [6] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11};
    logic [1:0] v038 [6] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
    logic [1:0] v042 [6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b01, 2'b11};

    tt_um_viterbi_core dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_sym_valid  (rx_sym_valid),
        .rx_sym_ready  (rx_sym_ready),
        .rx_sym        (rx_sym),
        .dec_bit_valid (dec_bit_valid),
        .dec_bit       (dec_bit),
        .force_state0  (force_state0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int par(input int v);
        return $countones(v) & 1;
    endfunction

    function automatic int enc_sym(input int sr);
        return (par(sr & G0) << 1) | par(sr & G1);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            pm[s]   = (s == 0) ? 0 : (1 << (WM - 2));
            path[s] = 0;
        end
        m_cnt = 0;
        exp_bit_q.delete();
        exp_cyc_q.delete();
    endtask

    // Each state keeps its whole survivor path; bit 0 is the newest decision.
    task automatic model_step(input int sym, input logic fs, input int acc_cyc);
        int              npm [NS];
        longint unsigned npath [NS];
        int              mn;
        int              start;
        for (int s = 0; s < NS; s++) begin
            for (int d = 0; d < 2; d++) begin
                int p;
                int c;
                p = (d << (M - 1)) | (s >> 1);
                c = pm[p] + $countones(enc_sym((d << M) | s) ^ sym);
                if (c > SAT) c = SAT;
                if (d == 0 || c < npm[s]) begin
                    npm[s]   = c;
                    npath[s] = (path[p] << 1) | longint'(s & 1);
                end
            end
        end
        mn = npm[0];
        for (int s = 1; s < NS; s++) if (npm[s] < mn) mn = npm[s];
        for (int s = 0; s < NS; s++) begin
            pm[s]   = npm[s] - mn;
            path[s] = npath[s];
        end
        if (m_cnt < D) m_cnt++;
        if (m_cnt >= D) begin
            start = 0;
            if (BEST_EN && !fs) begin
                for (int s = 1; s < NS; s++) if (pm[s] < pm[start]) start = s;
            end
            exp_bit_q.push_back(int'((path[start] >> (D - 1)) & 1));
            exp_cyc_q.push_back(acc_cyc + 1 + LAT);
        end
    endtask

    // Observe away from the active edge: accepts feed the model, strobes are scored.
    always @(negedge clk) begin
        if (!rst_n) begin
            check_eq("rst_ready", rx_sym_ready, 0);
            check_eq("rst_valid", dec_bit_valid, 0);
            model_reset();
        end else begin
            if (rx_sym_valid && rx_sym_ready) model_step(int'(rx_sym), force_state0, cyc);
            if (dec_bit_valid) begin
                strobes++;
                last_bit = int'(dec_bit);
                ones    += int'(dec_bit);
                check_eq("strobe_expected", exp_bit_q.size() > 0, 1);
                if (exp_bit_q.size() > 0) begin
                    check_eq("dec_bit", dec_bit, exp_bit_q.pop_front());
                    check_eq("latency", cyc, exp_cyc_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [1:0] s);
        int guard;
        guard        = 0;
        rx_sym       = s;
        rx_sym_valid = 1'b1;
        @(negedge clk);
        while (!rx_sym_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_wait", rx_sym_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic enc_send(input int b, input int flip, input bit gap);
        int sr;
        sr     = (enc_st << 1) | b;
        enc_st = sr & (NS - 1);
        send_sym(2'(enc_sym(sr) ^ flip));
        if (gap) begin
            rx_sym_valid = 1'b0;
            idle($urandom_range(0, 3));
        end
    endtask

    task automatic send_vec6(input logic [1:0] v [6]);
        for (int i = 0; i < 6; i++) begin
            send_sym(v[i]);
            rx_sym_valid = 1'b0;
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic pulse_reset();
        rx_sym_valid = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enc_st = 0;
    endtask

    task automatic drain();
        int guard;
        guard        = 0;
        rx_sym_valid = 1'b0;
        while (exp_bit_q.size() != 0 && guard < 4 * LAT) begin
            @(posedge clk);
            guard++;
        end
        idle(LAT + 2);
        check_eq("drain", exp_bit_q.size(), 0);
    endtask

    initial begin
        int s0;
        int o0;
        rst_n        = 1'b0;
        rx_sym_valid = 1'b0;
        rx_sym       = 2'b00;
        force_state0 = 1'b0;
        enc_st       = 0;
        model_reset();
        @(negedge clk);
        check_eq("reset_ready", rx_sym_ready, 0);
        check_eq("reset_valid", dec_bit_valid, 0);
        check_eq("reset_bit", dec_bit, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_reset", rx_sym_ready, 1);

        force_state0 = 1'b1;
        s0 = strobes;
        send_vec6(v037);
        drain();
        check_eq("r037_count", strobes - s0, 1);
        check_eq("r037_bit", last_bit, 1);

        pulse_reset();
        force_state0 = 1'b0;
        s0 = strobes;
        send_vec6(v038);
        drain();
        check_eq("r038_count", strobes - s0, 1);
        check_eq("r038_bit", last_bit, 1);

        pulse_reset();
        s0 = strobes;
        o0 = ones;
        for (int i = 0; i < 12; i++) enc_send(0, 0, 1'b1);
        drain();
        check_eq("r039_count", strobes - s0, 7);
        check_eq("r039_ones", ones - o0, 0);

        pulse_reset();
        force_state0 = 1'b1;
        s0 = strobes;
        send_vec6(v042);
        drain();
        check_eq("r042_count", strobes - s0, 1);
        check_eq("r042_bit", last_bit, 1);

        pulse_reset();
        force_state0 = 1'($urandom_range(0, 1));
        s0 = strobes;
        for (int i = 0; i < 30; i++) begin
            enc_send(int'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0) ? (1 << $urandom_range(0, 1)) : 0, 1'b0);
        end
        drain();
        check_eq("r040_count", strobes - s0, 30 - D + 1);

        pulse_reset();
        force_state0 = 1'b0;
        for (int i = 0; i < D; i++) enc_send(int'($urandom_range(0, 1)), 0, 1'b0);
        rx_sym_valid = 1'b0;
        idle(NS + 2);
        pulse_reset();
        s0 = strobes;
        idle(LAT + 4);
        check_eq("r041_abort", strobes - s0, 0);
        for (int i = 0; i < D - 1; i++) enc_send(int'($urandom_range(0, 1)), 0, 1'b1);
        idle(LAT + 4);
        check_eq("r041_early", strobes - s0, 0);
        enc_send(int'($urandom_range(0, 1)), 0, 1'b1);
        drain();
        check_eq("r041_first", strobes - s0, 1);

        for (int k = 0; k < 3; k++) begin
            force_state0 = 1'($urandom_range(0, 1));
            for (int i = 0; i < 20; i++) begin
                enc_send(int'($urandom_range(0, 1)),
                         ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b1);
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
